// File: rtl/ppi_bus_master.sv
// ppi_bus_master
//
// Bus initiator for a PPI-style peripheral. Each host request accepted on the
// valid/ready port becomes one PPI bus cycle made of three timed phases:
// setup (CS_N low, SEL/D valid), strobe (RD_N or WR_N low) and hold (strobe
// released, CS_N/SEL/D kept). When the hold phase ends, rsp_valid pulses for
// one cycle. For reads, rsp_data carries the byte sampled from D at the end of
// the strobe. For writes, rsp_data is 0x00.
//
// Parameters
//   SETUP_CYC   cycles of setup before the strobe (>= 1)
//   STROBE_CYC  cycles the strobe is held low  (>= 1)
//   HOLD_CYC    cycles of hold after the strobe (>= 1)
//
// Optional feature (compile-time macro PPI_BSR_HELPER_EN)
//   Adds req_bsr/req_bit/req_val. A request with req_bsr=1 is issued as a
//   control-word write (SEL=11) of {1'b0, 3'b000, req_bit, req_val}.
//
// Ports
//   CLK, RESET_N          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   host request handshake; accept on valid && ready
//   req_wr                1 = write, 0 = read
//   req_addr              PPI select (A, B, C, control)
//   req_wdata             write data
//   req_bsr/bit/val       bit set/reset helper (PPI_BSR_HELPER_EN only)
//   rsp_valid/rsp_data    one-cycle completion pulse and read data
//   CS_N, RD_N, WR_N      PPI chip select and strobes, active low
//   SEL                   PPI address
//   D                     PPI data bus; driven only during write cycles
module ppi_bus_master #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_wdata,
`ifdef PPI_BSR_HELPER_EN
    input  logic       req_bsr,
    input  logic [2:0] req_bit,
    input  logic       req_val,
`endif
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       CS_N,
    output logic       RD_N,
    output logic       WR_N,
    output logic [1:0] SEL,
    inout  wire  [7:0] D
);

    // Counter wide enough for the longest phase.
    localparam int unsigned MaxSt  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int unsigned MaxCyc = (MaxSt > HOLD_CYC) ? MaxSt : HOLD_CYC;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [CntW-1:0] SetupLd  = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] StrobeLd = CntW'(STROBE_CYC - 1);
    localparam logic [CntW-1:0] HoldLd   = CntW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Latched transaction and registered bus/response outputs.
    logic       wr_q, wr_d;
    logic       cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] dout_q, dout_d;
    logic       doe_q, doe_d;
    logic       ready_q, ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;

    logic       accept;
    logic       strobe_end;
    logic       eff_wr;
    logic [1:0] eff_addr;
    logic [7:0] eff_wdata;

    // ready_q is only high in IDLE, so it alone qualifies the handshake.
    assign accept = req_valid && ready_q;

`ifdef PPI_BSR_HELPER_EN
    // Bit set/reset helper: build the control word {0, 000, bit, val}.
    always_comb begin
        if (req_bsr) begin
            eff_wr    = 1'b1;
            eff_addr  = 2'b11;
            eff_wdata = {1'b0, 3'b000, req_bit, req_val};
        end else begin
            eff_wr    = req_wr;
            eff_addr  = req_addr;
            eff_wdata = req_wdata;
        end
    end
`else
    always_comb begin
        eff_wr    = req_wr;
        eff_addr  = req_addr;
        eff_wdata = req_wdata;
    end
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and phase counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        strobe_end  = 1'b0;
        rsp_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSetup;
                    cnt_d   = SetupLd;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StStrobe;
                    cnt_d   = StrobeLd;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    state_d    = StHold;
                    cnt_d      = HoldLd;
                    strobe_end = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Computed from the next state so the registered pins
    // change on the same edge as the state.
    // ------------------------------------------------------------------
    always_comb begin
        wr_d    = accept ? eff_wr    : wr_q;
        sel_d   = accept ? eff_addr  : sel_q;
        dout_d  = accept ? eff_wdata : dout_q;
        cs_n_d  = (state_d == StIdle);
        rd_n_d  = !((state_d == StStrobe) && !wr_d);
        wr_n_d  = !((state_d == StStrobe) && wr_d);
        doe_d   = (state_d != StIdle) && wr_d;
        ready_d = (state_d == StIdle);

        rsp_data_d = rsp_data_q;
        if (strobe_end && !wr_q) begin
            // Sampled on the edge that ends the strobe, while RD_N is still low.
            rsp_data_d = D;
        end else if (rsp_valid_d && wr_q) begin
            rsp_data_d = 8'h00;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            sel_q       <= 2'b00;
            dout_q      <= 8'h00;
            doe_q       <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            wr_q        <= wr_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            sel_q       <= sel_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign CS_N      = cs_n_q;
    assign RD_N      = rd_n_q;
    assign WR_N      = wr_n_q;
    assign SEL       = sel_q;
    assign D         = doe_q ? dout_q : 8'hzz;

endmodule
